// File: rtl/bus_ep_pkg.sv
// Shared definitions for the bus endpoint and for the agent/checker code
// that talks to it.
//   ID_W              - width of a destination id
//   DEFAULT_BROADCAST - destination id that every endpoint accepts
//   dest_of()         - extracts the destination id from a packet
package bus_ep_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] DEFAULT_BROADCAST = 8'hFF;
  localparam int PKT_MAX_W = 64;

  // Packets narrower than PKT_MAX_W are passed zero-extended; pkt_w is the
  // real packet width so the id is taken from the top ID_W bits of that width.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned pkt_w = 16);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/bus_endpoint_fifo.sv
// First-word-fall-through FIFO used for both endpoint directions.
//   clk, reset : clock, synchronous active-low reset (empties FIFO, clears storage)
//   wr, din    : write request and data; ignored when full unless a read also occurs
//   rd         : read request; ignored when empty
//   dout       : head entry (0 after reset)
//   empty/full : decoded from the registered occupancy counter
module ep_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] din,
  input  logic             rd,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_rd;
  logic             do_wr;

  assign empty = (count == '0);
  assign full  = (count == CW'(depth));
  assign dout  = mem[rd_ptr];

  // A read in the same cycle frees a slot, so a write at full still lands.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bus_endpoint.sv
// Per-device endpoint on the bs_gnrtr_n_rbtr bus.
//   clk, reset              : clock, synchronous active-low reset
//   pndng, D_pop, pop       : outbound queue toward the arbiter (FWFT head)
//   push, D_push            : inbound delivery from the bus, no backpressure
//   tx_valid/ready/data     : local transmit port
//   rx_valid/ready/data     : local receive port (FWFT)
//   rx_drop, rx_misroute,
//   pop_err                 : sticky error flags, cleared only by reset
//   rx_drop_cnt             : saturating count of dropped pushes
module bus_endpoint
  import bus_ep_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              depth     = 8,
  parameter logic [ID_W-1:0] id        = 8'd0,
  parameter logic [ID_W-1:0] broadcast = DEFAULT_BROADCAST
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_drop,
  output logic               rx_misroute,
  output logic               pop_err,
  output logic [15:0]        rx_drop_cnt
);

  logic            tx_empty;
  logic            tx_full;
  logic            rx_empty;
  logic            rx_full;
  logic            rx_accept;
  logic            rx_discard;
  logic [ID_W-1:0] push_dest;

  ep_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_valid && !tx_full),
    .din   (tx_data),
    .rd    (pop),
    .dout  (D_pop),
    .empty (tx_empty),
    .full  (tx_full)
  );

  ep_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .din   (D_push),
    .rd    (rx_ready),
    .dout  (rx_data),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign pndng    = !tx_empty;
  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  // Mirrors the FIFO's own acceptance rule: full only blocks when the local
  // side is not draining in the same cycle (full implies non-empty).
  assign rx_accept  = push && (!rx_full || rx_ready);
  assign rx_discard = push && rx_full && !rx_ready;
  assign push_dest  = dest_of(PKT_MAX_W'(D_push), pckg_sz);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_drop     <= 1'b0;
      rx_misroute <= 1'b0;
      pop_err     <= 1'b0;
      rx_drop_cnt <= '0;
    end else begin
      if (pop && tx_empty) pop_err <= 1'b1;
      if (rx_discard) begin
        rx_drop <= 1'b1;
        if (rx_drop_cnt != 16'hFFFF) rx_drop_cnt <= rx_drop_cnt + 1'b1;
      end
      if (rx_accept && push_dest != id && push_dest != broadcast)
        rx_misroute <= 1'b1;
    end
  end

endmodule

// File: doc/bus_endpoint.md
# bus_endpoint

Synthesizable per-device endpoint for the `bs_gnrtr_n_rbtr` bus, one instance per driver slot. Toward the bus it acts as the driver-side peer: it presents queued outbound packets on `pndng`/`D_pop`, which the arbiter consumes with `pop`, and it receives delivered packets on `push`/`D_push`. Toward the local device it exposes a valid/ready transmit port and a valid/ready receive port. It also provides destination checking and error flags.

## Interface
- `pckg_sz`, 16: packet width; bits `[pckg_sz-1:pckg_sz-8]` = destination id, `[pckg_sz-9:0]` = payload.
- `depth`, 8: entries per FIFO, power of two, ≥2.
- `id`, 0: this endpoint's 8-bit address.
- `broadcast`, 8'hFF: broadcast destination id.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `pndng` out 1: TX FIFO non-empty.
- `D_pop` out pckg_sz: TX FIFO head (first-word-fall-through).
- `pop` in 1: bus consumes TX head this cycle.
- `push` in 1: bus delivers `D_push` this cycle; no backpressure.
- `D_push` in pckg_sz: delivered packet.
- `tx_valid` in 1, `tx_ready` out 1, `tx_data` in pckg_sz: local transmit port.
- `rx_valid` out 1, `rx_ready` in 1, `rx_data` out pckg_sz: local receive port, first-word-fall-through.
- `rx_drop` out 1: sticky; a push arrived while RX was full.
- `rx_misroute` out 1: sticky; accepted packet whose dest ≠ `id` and ≠ `broadcast`.
- `pop_err` out 1: sticky; `pop` seen while `pndng`=0.
- `rx_drop_cnt` out 16: count of dropped pushes; saturates at 16'hFFFF.

## Operation
- **TX FIFO.**
  - Write occurs when `tx_valid && tx_ready`.
  - `tx_ready` = !tx_full; there is no full-bypass.
  - Read occurs when `pop && pndng`.
  - Simultaneous write and read when non-empty and non-full: both occur; count unchanged.
- **TX underflow.** `pop` while empty sets `pop_err`, and the FIFO is untouched. This includes a same-cycle write into an empty FIFO: the write happens and the pop is ignored.
- **RX FIFO, push handling.**
  - A push is always examined.
  - If not full, or if a read happens in the same cycle, the packet is stored.
  - Otherwise the packet is discarded, `rx_drop` is set and `rx_drop_cnt` increments.
- **RX FIFO, reads and destination check.**
  - Read occurs when `rx_valid && rx_ready`; `rx_valid` = !rx_empty.
  - Misrouted packets are still stored; the only effect is setting `rx_misroute`.
- **Pointers.** Read/write pointers are `$clog2(depth)` bits and wrap modulo `depth`. Occupancy is a `$clog2(depth)+1`-bit counter.
- **Sticky flags.** Cleared only by reset.

## Timing
- **Reset.** When `reset`=0 at a rising edge:
  - Both FIFOs are emptied.
  - All flags and `rx_drop_cnt` become 0.
  - `pndng`=0, `rx_valid`=0, `tx_ready`=1.
  - `D_pop` and `rx_data` are don't-care while empty and must be driven 0 from the storage reset.
- **Reset mid-operation.** In-flight entries are lost. The `pop`/`push` of the reset cycle is ignored.
- **TX latency.** `tx_data` written at edge N appears on `pndng`/`D_pop` after edge N, so it is poppable in cycle N+1.
- **RX latency.** `D_push` stored at edge N is visible on `rx_valid`/`rx_data` after edge N.
- **Status outputs.** `pndng`, `rx_valid`, `tx_ready` and the flags are decoded only from registered state; there is no combinational path from any input.

## Structure
- **Shared package `bus_ep_pkg`:**
  - `localparam ID_W = 8`.
  - `DEFAULT_BROADCAST = 8'hFF`.
  - Function `dest_of(pkt)` returning the upper 8 bits.
  - This package is shared with agent/checker code.
- **Sub-module `ep_fifo`:**
  - Parameters `width`, `depth`.
  - Ports `clk`, `reset`, `wr`, `din`, `rd`, `dout`, `empty`, `full`.
  - Write takes effect only when accepted.
  - Instantiated twice.
- **Top level:** acceptance logic, destination check, flags and the drop counter.

## Test plan
All scenarios use `pckg_sz`=16, `depth`=4, `id`=3.
- **Reset, then TX of 3 words.** Reset, then write 16'h0211, 16'h0222, 16'h0433 via `tx_*` → `pndng`=1 one cycle after the first write. Popping each cycle yields `D_pop` in order; `pndng`=0 after the third pop.
- **TX full.** Write 5 words without popping → `tx_ready`=0 after the 4th; the 5th is held by the source. Pop and write in the same cycle while full → exactly one word is accepted the cycle after `tx_ready` rises.
- **RX overflow.** Push 6 packets 16'h03A0..16'h03A5 with `rx_ready`=0 → A0..A3 are stored, `rx_drop`=1, `rx_drop_cnt`=2. Push at full with `rx_ready`=1 → the packet is stored and the count is unchanged.
- **Destination check.** Push 16'hFF55 → stored, `rx_misroute`=0. Push 16'h0755 → stored, `rx_misroute`=1.
- **Underflow.** `pop`=1 with an empty TX FIFO, together with a simultaneous `tx` write of 16'h0101 → `pop_err`=1. The word remains and `pndng`=1 next cycle.
- **Mid-operation reset.** `reset`=0 for one cycle with 2 words in each FIFO and all flags set → the next cycle shows `pndng`=0, `rx_valid`=0, all flags 0, `rx_drop_cnt`=0.
